// File: rtl/zone_stat_scheduler.sv
// -----------------------------------------------------------------------------
// zone_stat_scheduler
//
// Purpose:
//   Local-dimming zone statistics for a mini-LED backlight. Pixels arrive as a
//   registered gray stream with their coordinates. For every zone in the
//   current zone-row band the block tracks the peak gray level and the gray
//   sum. When a band completes, its 16 records {zone_x, zone_y, max, mean} are
//   drained over a valid/ready stream while the next band accumulates into the
//   other bank. If the previous band is still draining when a new band
//   completes, the new band is dropped and counted.
//
// Ports:
//   i_pix_clk   pixel clock (only clock)
//   rst_n       asynchronous active-low reset
//   gray_de     data_gray / pix_x / pix_y valid this cycle
//   data_gray   8-bit gray pixel value
//   pix_x       pixel column, 1..H_ACT
//   pix_y       pixel row,    1..V_ACT
//   zone_valid  zone record valid
//   zone_ready  downstream accepts the record when zone_valid && zone_ready
//   zone_x      zone column of the record
//   zone_y      zone row of the record
//   zone_max    peak gray in the zone
//   zone_avg    mean gray in the zone, clamped to 255
//   frame_done  1-cycle pulse after the last record of the last band is accepted
//   band_drop   1-cycle pulse when a completed band is discarded
//   drop_cnt    saturating count of dropped bands since reset
// -----------------------------------------------------------------------------
module zone_stat_scheduler #(
   parameter int H_ACT     = 1280,
   parameter int V_ACT     = 800,
   parameter int ZONE_W    = 80,
   parameter int ZONE_H    = 80,
   parameter int AVG_MUL   = 41,
   parameter int AVG_SHIFT = 18
) (
   input  logic        i_pix_clk,
   input  logic        rst_n,
   input  logic        gray_de,
   input  logic [7:0]  data_gray,
   input  logic [10:0] pix_x,
   input  logic [10:0] pix_y,
   output logic        zone_valid,
   input  logic        zone_ready,
   output logic [3:0]  zone_x,
   output logic [3:0]  zone_y,
   output logic [7:0]  zone_max,
   output logic [7:0]  zone_avg,
   output logic        frame_done,
   output logic        band_drop,
   output logic [7:0]  drop_cnt
);

   localparam int ZONES_X = H_ACT / ZONE_W;
   localparam int ZONES_Y = V_ACT / ZONE_H;
   localparam int SUM_W   = $clog2(ZONE_W * ZONE_H * 255 + 1);
   localparam int MUL_W   = $clog2(AVG_MUL + 1);
   localparam int PROD_W  = SUM_W + MUL_W;
   localparam int CW      = $clog2(ZONE_W + 1);
   localparam int RW      = $clog2(ZONE_H + 1);

   localparam logic [10:0]     H_LAST   = 11'(H_ACT);
   localparam logic [CW-1:0]   COL_WRAP = CW'(ZONE_W);
   localparam logic [RW-1:0]   ROW_WRAP = RW'(ZONE_H);
   localparam logic [3:0]      LAST_K   = 4'(ZONES_X - 1);
   localparam logic [3:0]      LAST_ZY  = 4'(ZONES_Y - 1);
   localparam logic [PROD_W-1:0] AVG_CLAMP = PROD_W'(255);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // ---------------------------------------------------------------------------
   // Zone position tracking. The _d values are the position of the pixel on
   // the inputs this cycle; the _q values are the position of the last pixel.
   // ---------------------------------------------------------------------------
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [3:0]    zx_q, zx_d;
   logic [3:0]    zy_q, zy_d;
   logic          band_end_q, band_end_d;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      col_d = col_q;
      zx_d  = zx_q;
      row_d = row_q;
      zy_d  = zy_q;
      if (gray_de) begin
         if (pix_x == 11'd1) begin
            col_d = CW'(1);
            zx_d  = 4'd0;
            if (pix_y == 11'd1) begin
               row_d = RW'(1);
               zy_d  = 4'd0;
            end else if (row_q == ROW_WRAP) begin
               row_d = RW'(1);
               zy_d  = zy_q + 4'd1;
            end else begin
               row_d = row_q + RW'(1);
            end
         end else if (col_q == COL_WRAP) begin
            col_d = CW'(1);
            zx_d  = zx_q + 4'd1;
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Last pixel of the last line of a zone row (cycle N).
   assign band_end_d = gray_de && (pix_x == H_LAST) && (row_d == ROW_WRAP);

   // ---------------------------------------------------------------------------
   // Drain control state
   // ---------------------------------------------------------------------------
   logic [0:0] state_q, state_d;
   logic       sel_q, sel_d;         // bank currently accumulating
   logic [3:0] k_q, k_d;             // entry currently presented
   logic [3:0] band_zy_q, band_zy_d;
   logic       valid_q, valid_d;
   logic [7:0] max_q, max_d;
   logic [7:0] avg_q, avg_d;
   logic       frame_done_q, frame_done_d;
   logic [7:0] drop_cnt_q, drop_cnt_d;

   // A swap happens the cycle after band end, only if nothing is draining.
   logic swap;
   assign swap = band_end_q && (state_q == ST_IDLE);

   // ---------------------------------------------------------------------------
   // Two banks of 16 x {max, sum}
   // ---------------------------------------------------------------------------
   logic [7:0]       max_mem [2][16];
   logic [SUM_W-1:0] sum_mem [2][16];

   logic             wr_bank;
   logic             first_pix;
   logic [7:0]       acc_max, new_max;
   logic [SUM_W-1:0] acc_sum, new_sum;

   // The pixel arriving on the swap cycle already belongs to the next band,
   // so it must land in the bank that is about to become the accumulator.
   always_comb begin
      wr_bank   = swap ? ~sel_q : sel_q;
      first_pix = (col_d == CW'(1)) && (row_d == RW'(1));
      acc_max   = max_mem[wr_bank][zx_d];
      acc_sum   = sum_mem[wr_bank][zx_d];
      if (first_pix) begin
         new_max = data_gray;
         new_sum = SUM_W'(data_gray);
      end else begin
         new_max = (data_gray > acc_max) ? data_gray : acc_max;
         new_sum = acc_sum + SUM_W'(data_gray);
      end
   end

   // NOTE: bank storage has no reset; every entry is overwritten by the first
   // pixel of its zone before it can be drained, so stale contents never leak.
   always_ff @(posedge i_pix_clk) begin
      if (gray_de) begin
         max_mem[wr_bank][zx_d] <= new_max;
         sum_mem[wr_bank][zx_d] <= new_sum;
      end
   end

   // ---------------------------------------------------------------------------
   // Drain read path: entry 0 of the freshly completed bank on a swap,
   // otherwise the entry following the one currently presented.
   // ---------------------------------------------------------------------------
   logic              rd_bank;
   logic [3:0]        rd_idx;
   logic [7:0]        rd_max;
   logic [SUM_W-1:0]  rd_sum;
   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] avg_wide;
   logic [7:0]        rd_avg;

   always_comb begin
      rd_bank  = swap ? sel_q : ~sel_q;
      rd_idx   = swap ? 4'd0 : k_q + 4'd1;
      rd_max   = max_mem[rd_bank][rd_idx];
      rd_sum   = sum_mem[rd_bank][rd_idx];
      prod     = PROD_W'(rd_sum) * PROD_W'(AVG_MUL);
      avg_wide = prod >> AVG_SHIFT;
      rd_avg   = (avg_wide > AVG_CLAMP) ? 8'hFF : avg_wide[7:0];
   end

   // ---------------------------------------------------------------------------
   // Drain FSM
   // ---------------------------------------------------------------------------
   logic accept;
   assign accept = valid_q && zone_ready;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      k_d          = k_q;
      band_zy_d    = band_zy_q;
      valid_d      = valid_q;
      max_d        = max_q;
      avg_d        = avg_q;
      frame_done_d = 1'b0;
      drop_cnt_d   = drop_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (band_end_q) begin
               state_d   = ST_DRAIN;
               sel_d     = ~sel_q;
               k_d       = 4'd0;
               band_zy_d = zy_q;   // still the zone row of pixel N
               valid_d   = 1'b1;
               max_d     = rd_max;
               avg_d     = rd_avg;
            end
         end
         ST_DRAIN: begin
            if (band_end_q && (drop_cnt_q != 8'hFF)) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
            if (accept) begin
               if (k_q == LAST_K) begin
                  state_d      = ST_IDLE;
                  valid_d      = 1'b0;
                  frame_done_d = (band_zy_q == LAST_ZY);
               end else begin
                  k_d   = k_q + 4'd1;
                  max_d = rd_max;
                  avg_d = rd_avg;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of the others regardless of evaluation order.
   always_ff @(posedge i_pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         zx_q         <= '0;
         zy_q         <= '0;
         band_end_q   <= 1'b0;
         state_q      <= ST_IDLE;
         sel_q        <= 1'b0;
         k_q          <= '0;
         band_zy_q    <= '0;
         valid_q      <= 1'b0;
         max_q        <= '0;
         avg_q        <= '0;
         frame_done_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         zx_q         <= zx_d;
         zy_q         <= zy_d;
         band_end_q   <= band_end_d;
         state_q      <= state_d;
         sel_q        <= sel_d;
         k_q          <= k_d;
         band_zy_q    <= band_zy_d;
         valid_q      <= valid_d;
         max_q        <= max_d;
         avg_q        <= avg_d;
         frame_done_q <= frame_done_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign zone_valid = valid_q;
   assign zone_x     = k_q;
   assign zone_y     = band_zy_q;
   assign zone_max   = max_q;
   assign zone_avg   = avg_q;
   assign frame_done = frame_done_q;
   assign band_drop  = band_end_q && (state_q == ST_DRAIN);
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_zone_stat_scheduler.sv
// -----------------------------------------------------------------------------
// tb_zone_stat_scheduler
//
// Drives whole frames into a scaled-down zone_stat_scheduler: 64x20 pixels,
// 4x2-pixel zones, giving the same 16x10 zone grid as the full-size design.
// The mean uses (sum*129)>>10, close to sum/8; all-255 zones give a raw
// value of 256 so the clamp is exercised.
// -----------------------------------------------------------------------------
module tb_zone_stat_scheduler;

   localparam int H   = 64;
   localparam int V   = 20;
   localparam int ZW  = 4;
   localparam int ZH  = 2;
   localparam int MUL = 129;
   localparam int SH  = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gray_de = 1'b0;
   logic [7:0]  data_gray = '0;
   logic [10:0] pix_x = '0;
   logic [10:0] pix_y = '0;
   logic        zone_ready = 1'b1;
   logic        zone_valid;
   logic [3:0]  zone_x, zone_y;
   logic [7:0]  zone_max, zone_avg;
   logic        frame_done, band_drop;
   logic [7:0]  drop_cnt;

   always #5 clk = ~clk;

   zone_stat_scheduler #(
      .H_ACT(H), .V_ACT(V), .ZONE_W(ZW), .ZONE_H(ZH),
      .AVG_MUL(MUL), .AVG_SHIFT(SH)
   ) dut (
      .i_pix_clk (clk),
      .rst_n     (rst_n),
      .gray_de   (gray_de),
      .data_gray (data_gray),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .zone_valid(zone_valid),
      .zone_ready(zone_ready),
      .zone_x    (zone_x),
      .zone_y    (zone_y),
      .zone_max  (zone_max),
      .zone_avg  (zone_avg),
      .frame_done(frame_done),
      .band_drop (band_drop),
      .drop_cnt  (drop_cnt)
   );

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic [7:0] mx;
      logic [7:0] av;
   } rec_t;

   // mode 0: every pixel = bg except one pixel (sx,sy) = sv.
   // mode 1: every pixel of zone (zx,zy) = zx*16+zy.
   typedef struct {
      string name;
      int    mode;
      int    bg;
      int    sx;
      int    sy;
      int    sv;
      int    gap;
      int    bmax;
      int    bavg;
      int    smax;
      int    savg;
   } vec_t;

   int   n_cmp  = 0;
   int   n_fail = 0;
   rec_t recs[$];
   int   fd_cnt = 0;
   int   drop_pulses = 0;
   logic abort = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // --------------------------------------------------------------------------
   // Output monitor: collects accepted records, counts pulses, and checks that
   // a stalled record holds until it is accepted.
   // --------------------------------------------------------------------------
   logic prev_stall = 1'b0;
   logic prev_acc_last = 1'b0;
   rec_t prev_rec = '0;

   always @(negedge clk) begin
      rec_t cur;
      cur = '{x: zone_x, y: zone_y, mx: zone_max, av: zone_avg};
      if (!rst_n) begin
         prev_stall    <= 1'b0;
         prev_acc_last <= 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", {7'd0, zone_valid, cur}, {7'd0, 1'b1, prev_rec});
         if (frame_done) begin
            fd_cnt++;
            check("frame_done_after_last", 32'(prev_acc_last), 1);
         end
         if (band_drop) drop_pulses++;
         if (zone_valid && zone_ready) recs.push_back(cur);
         prev_acc_last <= zone_valid && zone_ready && zone_x == 4'd15 && zone_y == 4'd9;
         prev_stall    <= zone_valid && !zone_ready;
         prev_rec      <= cur;
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus and reference model
   // --------------------------------------------------------------------------
   function automatic logic [7:0] pix_val(input vec_t v, input int x, input int y);
      if (v.mode == 1) return 8'(((x - 1) / ZW) * 16 + (y - 1) / ZH);
      return (x == v.sx && y == v.sy) ? 8'(v.sv) : 8'(v.bg);
   endfunction

   function automatic int model_avg(input int sum);
      int a;
      a = (sum * MUL) >> SH;
      return (a > 255) ? 255 : a;
   endfunction

   function automatic rec_t exp_rec(input vec_t v, input int zx, input int zy);
      rec_t e;
      e.x = 4'(zx);
      e.y = 4'(zy);
      if (v.mode == 1) begin
         e.mx = 8'(zx * 16 + zy);
         e.av = 8'(model_avg(ZW * ZH * (zx * 16 + zy)));
      end else if (zx == (v.sx - 1) / ZW && zy == (v.sy - 1) / ZH) begin
         e.mx = 8'(v.smax);
         e.av = 8'(v.savg);
      end else begin
         e.mx = 8'(v.bmax);
         e.av = 8'(v.bavg);
      end
      return e;
   endfunction

   task automatic run_frame(input vec_t v);
      int n = 0;
      for (int y = 1; y <= V; y++) begin
         for (int x = 1; x <= H; x++) begin
            if (abort) begin
               gray_de = 1'b0;
               return;
            end
            gray_de   = 1'b1;
            pix_x     = 11'(x);
            pix_y     = 11'(y);
            data_gray = pix_val(v, x, y);
            step();
            n++;
            if (v.gap > 0 && (n % v.gap) == 0) begin
               gray_de = 1'b0;
               step();
            end
         end
         gray_de = 1'b0;
         step();
         step();
      end
   endtask

   task automatic check_frame(input vec_t v, input int skip_zy, input string tag);
      int idx = 0;
      check({tag, "_count"}, recs.size(), (skip_zy >= 0) ? 144 : 160);
      for (int zy = 0; zy < 10; zy++) begin
         if (zy != skip_zy) begin
            for (int zx = 0; zx < 16; zx++) begin
               if (idx < recs.size()) check({tag, "_rec"}, {8'd0, recs[idx]}, {8'd0, exp_rec(v, zx, zy)});
               idx++;
            end
         end
      end
   endtask

   task automatic wait_acc(input int n, input string tag);
      int t = 0;
      while (recs.size() < n && t < 4000) begin
         step();
         t++;
      end
      check(tag, 32'(recs.size() >= n), 1);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // --------------------------------------------------------------------------
   // Test sequence
   // --------------------------------------------------------------------------
   vec_t vecs[5];
   vec_t zid;

   initial begin
      int fd0, dp0, n0, t;

      // Hand-computed: flat v -> sum 8v, avg (8v*129)>>10.
      vecs[0] = '{name:"flat100",   mode:0, bg:100, sx:1,  sy:1,  sv:100, gap:0, bmax:100, bavg:100, smax:100, savg:100};
      vecs[1] = '{name:"spike255",  mode:0, bg:0,   sx:9,  sy:3,  sv:255, gap:5, bmax:0,   bavg:0,   smax:255, savg:32};
      vecs[2] = '{name:"flat255",   mode:0, bg:255, sx:1,  sy:1,  sv:255, gap:0, bmax:255, bavg:255, smax:255, savg:255};
      vecs[3] = '{name:"last_pix",  mode:0, bg:40,  sx:64, sy:20, sv:200, gap:3, bmax:40,  bavg:40,  smax:200, savg:60};
      vecs[4] = '{name:"first_pix", mode:0, bg:7,   sx:1,  sy:1,  sv:0,   gap:0, bmax:7,   bavg:7,   smax:7,   savg:6};
      zid     = '{name:"zone_id",   mode:1, bg:0,   sx:0,  sy:0,  sv:0,   gap:0, bmax:0,   bavg:0,   smax:0,   savg:0};

      // Reset state
      idle(3);
      check("rst_valid",      zone_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_band_drop",  band_drop,  0);
      check("rst_drop_cnt",   drop_cnt,   0);
      check("rst_zone_data",  {zone_x, zone_y, zone_max, zone_avg}, 0);
      rst_n = 1'b1;
      idle(2);

      // Table-driven full frames with ready held high
      for (int i = 0; i < 5; i++) begin
         recs.delete();
         fd0 = fd_cnt;
         dp0 = drop_pulses;
         run_frame(vecs[i]);
         idle(80);
         check_frame(vecs[i], -1, vecs[i].name);
         check({vecs[i].name, "_frame_done"}, fd_cnt - fd0, 1);
         check({vecs[i].name, "_band_drop"},  drop_pulses - dp0, 0);
         check({vecs[i].name, "_drop_cnt"},   drop_cnt, 0);
      end

      // Ready low for 50 cycles after 5 accepts
      recs.delete();
      fd0 = fd_cnt;
      dp0 = drop_pulses;
      fork
         run_frame(zid);
         begin
            wait_acc(5, "stall_reach5");
            zone_ready = 1'b0;
            n0 = recs.size();
            idle(50);
            check("stall_no_accept", recs.size(), n0);
            check("stall_valid_held", zone_valid, 1);
            zone_ready = 1'b1;
         end
      join
      idle(80);
      check_frame(zid, -1, "stall");
      check("stall_frame_done", fd_cnt - fd0, 1);
      check("stall_band_drop",  drop_pulses - dp0, 0);

      // Ready held low across the next band end: band 1 is dropped
      recs.delete();
      fd0 = fd_cnt;
      dp0 = drop_pulses;
      fork
         run_frame(zid);
         begin
            wait_acc(3, "drop_reach3");
            zone_ready = 1'b0;
            t = 0;
            while (drop_pulses == dp0 && t < 1000) begin
               step();
               t++;
            end
            check("drop_seen", 32'(drop_pulses != dp0), 1);
            idle(5);
            check("drop_cnt_mid", drop_cnt, 1);
            zone_ready = 1'b1;
         end
      join
      idle(80);
      check_frame(zid, 1, "drop");
      check("drop_pulses",    drop_pulses - dp0, 1);
      check("drop_cnt_end",   drop_cnt, 1);
      check("drop_frame_done", fd_cnt - fd0, 1);

      // Reset for 3 cycles mid-drain, then a fresh frame
      recs.delete();
      fork
         run_frame(zid);
         begin
            wait_acc(5, "rst_reach5");
            check("pre_rst_drop_cnt", drop_cnt, 1);
            rst_n = 1'b0;
            abort = 1'b1;
            #1;
            check("midrst_valid",    zone_valid, 0);
            check("midrst_drop_cnt", drop_cnt, 0);
            check("midrst_data",     {zone_x, zone_y, zone_max, zone_avg}, 0);
            idle(3);
            check("midrst_held", {zone_valid, frame_done, band_drop, drop_cnt}, 0);
            rst_n = 1'b1;
         end
      join
      abort = 1'b0;
      idle(5);
      recs.delete();
      fd0 = fd_cnt;
      dp0 = drop_pulses;
      run_frame(zid);
      idle(80);
      check_frame(zid, -1, "post_rst");
      check("post_rst_frame_done", fd_cnt - fd0, 1);
      check("post_rst_band_drop",  drop_pulses - dp0, 0);
      check("post_rst_drop_cnt",   drop_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
